// File: rtl/li_seq_gen_pkg.sv
// li_seq_gen_pkg: RV32I encoding constants and FSM states for the LI/JMP sequence generator
package li_seq_gen_pkg;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic LI_OP_LI = 1'b0;
  localparam logic LI_OP_JMP = 1'b1;
  typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;
endpackage

// File: rtl/li_seq_gen_if.sv
// li_seq_gen_if: request and instruction-stream handshakes of the sequence generator
interface li_seq_gen_if;
  logic req_valid;
  logic req_ready;
  logic req_op;
  logic [4:0] req_rd;
  logic [31:0] req_value;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] inst;
  logic inst_last;
  logic err;
  modport master(output req_valid, req_op, req_rd, req_value, inst_ready,
                 input req_ready, inst_valid, inst, inst_last, err);
  modport slave(input req_valid, req_op, req_rd, req_value, inst_ready,
                output req_ready, inst_valid, inst, inst_last, err);
endinterface

// File: rtl/li_split.sv
// li_split: splits a constant into LUI upper part (rounded for sign-extended low part) and low 12 bits
module li_split (
  input logic [31:0] value,
  output logic [19:0] hi,
  output logic [11:0] lo,
  output logic hi_zero,
  output logic lo_zero
);
  // (value + 0x800) >> 12 without keeping the unused low sum bits
  assign hi = value[31:12] + {19'b0, value[11]};
  assign lo = value[11:0];
  assign hi_zero = hi == 20'b0;
  assign lo_zero = lo == 12'b0;
endmodule

// File: rtl/li_seq_gen.sv
// li_seq_gen: emits the minimal RV32I sequence that loads a constant (LI) or jumps to an absolute address (JMP)
module li_seq_gen
  import li_seq_gen_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input logic clk,
  input logic rst,
  li_seq_gen_if.slave bus
);
  state_t state, state_n;
  logic [31:0] inst_q, inst_n, inst2_q, inst2_n, first, second;
  logic last_q, last_n, two_q, two_n, err_q, err_n, live;
  logic [19:0] hi;
  logic [11:0] lo;
  logic hi_zero, lo_zero, is_jmp, rd_zero, two, bad;
  li_split u_split (
    .value(bus.req_value),
    .hi(hi),
    .lo(lo),
    .hi_zero(hi_zero),
    .lo_zero(lo_zero)
  );
  assign is_jmp = bus.req_op == LI_OP_JMP;
  assign rd_zero = bus.req_rd == 5'd0;
  assign first = is_jmp ? (hi_zero ? {lo, 5'd0, 3'b000, 5'd0, OPC_JALR} : {hi, bus.req_rd, OPC_LUI})
               : rd_zero ? NOP_INST
               : hi_zero ? {lo, 5'd0, F3_ADDI, bus.req_rd, OPC_OPIMM}
               : {hi, bus.req_rd, OPC_LUI};
  assign second = is_jmp ? {lo, bus.req_rd, 3'b000, 5'd0, OPC_JALR}
                : {lo, bus.req_rd, F3_ADDI, bus.req_rd, OPC_OPIMM};
  assign two = is_jmp ? !hi_zero : !rd_zero && !hi_zero && !lo_zero;
  assign bad = is_jmp && !hi_zero && rd_zero;
  assign bus.req_ready = state == IDLE && live;
  assign bus.inst_valid = state != IDLE;
  assign bus.inst = inst_q;
  assign bus.inst_last = last_q;
  assign bus.err = err_q;
  always_comb begin
    state_n = state;
    inst_n = inst_q;
    inst2_n = inst2_q;
    last_n = last_q;
    two_n = two_q;
    err_n = 1'b0;
    case (state)
      IDLE: if (bus.req_valid && live) begin
        err_n = bad;
        state_n = bad ? IDLE : EMIT1;
        inst_n = bad ? 32'b0 : first;
        inst2_n = second;
        two_n = two;
        last_n = !bad && !two;
      end
      EMIT1: if (bus.inst_ready) begin
        state_n = two_q ? EMIT2 : IDLE;
        inst_n = two_q ? inst2_q : 32'b0;
        last_n = two_q;
      end
      default: if (bus.inst_ready) begin
        state_n = IDLE;
        inst_n = 32'b0;
        last_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      inst_q <= 32'b0;
      inst2_q <= 32'b0;
      last_q <= 1'b0;
      two_q <= 1'b0;
      err_q <= 1'b0;
      live <= 1'b0;
    end else begin
      state <= state_n;
      inst_q <= inst_n;
      inst2_q <= inst2_n;
      last_q <= last_n;
      two_q <= two_n;
      err_q <= err_n;
      live <= 1'b1;
    end
  end
endmodule

// File: tb/tb_li_seq_gen.sv
// tb_li_seq_gen: scoreboard bench; expected instructions queued at request time, checked at each handshake
module tb_li_seq_gen;
  import li_seq_gen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] sb[$];
  li_seq_gen_if bus ();
  li_seq_gen #(.NOP_INST(32'h00000013)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic op, input logic [4:0] rd, input logic [31:0] val);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("req_timeout", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_rd = rd;
    bus.req_value = val;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_value = 32'hA5A5A5A5;
  endtask
  task automatic pop(input string tag, input int stall);
    logic [32:0] exp;
    logic [31:0] hold;
    int n = 0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    exp = sb.pop_front();
    while (!bus.inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
    hold = bus.inst;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {31'b0, bus.inst_valid, bus.inst}, {31'b0, 1'b1, hold});
      chk({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
    end
    chk(tag, {31'b0, bus.inst_last, bus.inst}, {31'b0, exp});
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = LI_OP_LI;
    bus.req_rd = 5'd0;
    bus.req_value = 32'b0;
    bus.inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {59'b0, bus.req_ready, bus.inst_valid, bus.inst_last, bus.err, |bus.inst}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back({1'b0, 32'h123452B7});
    sb.push_back({1'b1, 32'h67828293});
    req(LI_OP_LI, 5'd5, 32'h12345678);
    pop("li_x5_lui", 0);
    pop("li_x5_addi", 0);
    sb.push_back({1'b0, 32'h000010B7});
    sb.push_back({1'b1, 32'hFFF08093});
    req(LI_OP_LI, 5'd1, 32'h00000FFF);
    pop("li_carry_lui", 0);
    pop("li_carry_addi", 1);
    sb.push_back({1'b1, 32'h80000113});
    req(LI_OP_LI, 5'd2, 32'hFFFFF800);
    pop("li_wrap_addi", 0);
    sb.push_back({1'b1, 32'h000101B7});
    req(LI_OP_LI, 5'd3, 32'h00010000);
    pop("li_lui_only", 0);
    sb.push_back({1'b0, 32'h80000337});
    sb.push_back({1'b1, 32'h00430067});
    req(LI_OP_JMP, 5'd6, 32'h80000004);
    pop("jmp_lui", 3);
    pop("jmp_jalr", 3);
    chk("jmp_ready_after", 64'(bus.req_ready), 64'd1);
    sb.push_back({1'b1, 32'h12300067});
    req(LI_OP_JMP, 5'd7, 32'h00000123);
    pop("jmp_low", 0);
    req(LI_OP_JMP, 5'd0, 32'h00001000);
    chk("err_pulse", {62'b0, bus.err, bus.inst_valid}, {62'b0, 1'b1, 1'b0});
    @(negedge clk);
    chk("err_drop", {62'b0, bus.err, bus.inst_valid}, 64'd0);
    sb.push_back({1'b1, 32'h00000013});
    req(LI_OP_LI, 5'd0, 32'hDEADBEEF);
    pop("li_x0_nop", 0);
    sb.push_back({1'b0, 32'h123452B7});
    req(LI_OP_LI, 5'd5, 32'h12345678);
    pop("mid_lui", 0);
    chk("mid_emit2", {31'b0, bus.inst_valid, bus.inst}, {31'b0, 1'b1, 32'h67828293});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {59'b0, bus.req_ready, bus.inst_valid, bus.inst_last, bus.err, |bus.inst}, 64'd0);
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_emit", 64'(bus.inst_valid), 64'd0);
    end
    bus.inst_ready = 1'b0;
    sb.push_back({1'b0, 32'h000010B7});
    sb.push_back({1'b1, 32'hFFF08093});
    req(LI_OP_LI, 5'd1, 32'h00000FFF);
    pop("post_rst_lui", 0);
    pop("post_rst_addi", 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/li_seq_gen.md
Name: li_seq_gen

Overview:
- Encoder counterpart of the core's immediate generator: takes a 32-bit constant and splits it into RV32I U-type and I-type immediate fields.
- Emits the minimal instruction sequence that materialises the constant in a register (LI), or that jumps to it as an absolute address (JMP).
- Sits between the debug/program-buffer logic and the instruction-injection path.
- Valid/ready on both sides, one instruction out per handshake.

Parameters:
- NOP_INST, 32'h00000013, instruction emitted for LI with rd = x0

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  1  0 = LI, 1 = JMP
- req_rd  input  5  destination register (LI) or scratch register (JMP)
- req_value  input  32  constant or absolute target
- inst_valid  output  1  inst holds a valid instruction
- inst_ready  input  1  consumer accepts inst
- inst  output  32  encoded instruction
- inst_last  output  1  inst is the final instruction of the sequence
- err  output  1  one-cycle pulse: request rejected

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- While rst is high:
  - state goes to IDLE.
  - req_ready = 0, inst_valid = 0, inst = 0, inst_last = 0, err = 0.
  - req_ready rises the cycle after rst deasserts.
- Reset mid-sequence aborts it. No further instructions are emitted.
- Split on accept (registered):
  - hi = (req_value + 32'h800)[31:12]. The addition wraps modulo 2^32.
  - lo = req_value[11:0].
- Encodings:
  - LUI = {hi, rd, 7'b0110111}
  - ADDI = {lo, rs1, 3'b000, rd, 7'b0010011}
  - JALR = {lo, rs1, 3'b000, 5'd0, 7'b1100111}
- Sequence selection:
  - LI, rd = 0: NOP_INST only.
  - LI, hi = 0: ADDI rd, x0, lo only.
  - LI, lo = 0, hi ≠ 0: LUI rd, hi only.
  - LI otherwise: LUI rd, hi, then ADDI rd, rd, lo.
  - JMP, hi = 0: JALR x0, lo(x0) only.
  - JMP, hi ≠ 0, rd ≠ 0: LUI rd, hi, then JALR x0, lo(rd).
  - JMP, hi ≠ 0, rd = 0: nothing emitted. err pulses the cycle after accept. The block returns to IDLE.
- FSM:
  - States: IDLE, EMIT1, EMIT2.
  - req_ready = (state == IDLE), combinational from state.
  - IDLE: on req_valid, latch op/rd/hi/lo and go to EMIT1 (or stay in IDLE with err for the error case).
  - EMIT1: inst_valid = 1 with the first instruction. On inst_valid & inst_ready, go to EMIT2 if a second instruction exists, else to IDLE.
  - EMIT2: second instruction. On handshake, go to IDLE.
- Latency and throughput:
  - Request accepted in cycle N gives inst_valid in N+1.
  - Next request can be accepted the cycle after the last handshake.
  - No overlap between requests; one request at most every 2 cycles for single-instruction sequences.
- Output stability:
  - inst, inst_last and inst_valid are registered.
  - They hold stable while inst_valid & !inst_ready (backpressure of any length).
- inst_last = 1 on the final instruction of a sequence only.
- Inputs are ignored when req_ready = 0.

Decomposition:
- Shared package holds:
  - opcode constants OPC_LUI, OPC_OPIMM, OPC_JALR.
  - F3_ADDI.
  - op codes LI_OP_LI, LI_OP_JMP.
  - state enum IDLE/EMIT1/EMIT2.
- One natural sub-module: li_split. Combinational; value in → hi, lo, hi_zero, lo_zero out. It is reusable by other immediate-building logic.
- Encoding muxes stay in the top.

Test Plan:
- LI x5, 32'h12345678 → 32'h123452B7 (last=0), then 32'h67828293 (last=1).
- LI x1, 32'h00000FFF (carry case) → 32'h000010B7, then 32'hFFF08093.
- LI x2, 32'hFFFFF800 (hi wraps to 0) → single 32'h80000113, last=1. LI x3, 32'h00010000 → single 32'h000101B7.
- JMP x6, 32'h80000004 with inst_ready low for 3 cycles on each instruction → 32'h80000337 then 32'h00430067. inst is held stable throughout; req_ready stays 0 until after the second handshake.
- Error cases: JMP x0, 32'h00001000 → err pulse one cycle, no inst_valid. LI x0, any value → 32'h00000013.
- rst asserted in EMIT2 of an LI sequence → all outputs 0 next cycle, and no EMIT2 output afterwards. A new LI request is handled normally after rst drops.
